lab3_div_sequencer: RTL and testbench

//   Clocked sequencer for the lab3 divider datapath. Synchronises and debounces the four push-buttons and issues
//   one-cycle load/start pulses to the operand registers and divider. Waits for the divider to finish, with a

---
 rtl/lab3_div_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_lab3_div_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_div_sequencer.sv
// Button-driven sequencer for the lab3 divider: synchronises and debounces four buttons,
// issues load/start pulses, waits for the divider with a timeout and owns the display select.
module lab3_div_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int TO_W            = 7
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       DIV_DONE,
  output logic       dividendLOAD,
  output logic       divisorLOAD,
  output logic       trigger,
  output logic       remainderDISPLAY,
  output logic       busy,
  output logic       error,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]           btn_raw;
  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           db_q, db_d, db_prev_q;
  logic [3:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]           press;
  logic                 ev_left, ev_right, ev_up, ev_down;

  state_t               state_q, state_d;
  logic                 dvd_load_q, dvd_load_d;
  logic                 dvs_load_q, dvs_load_d;
  logic                 trig_q, trig_d;
  logic                 rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 dvd_ok_q, dvd_ok_d;
  logic                 dvs_ok_q, dvs_ok_d;
  logic                 res_ok_q, res_ok_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

  // Bit order everywhere: 0 = LEFT, 1 = RIGHT, 2 = UP, 3 = DOWN
  assign btn_raw = {DOWN, UP, RIGHT, LEFT};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle press events, resolved by fixed priority so only one acts
  assign press    = db_q & ~db_prev_q;
  assign ev_left  = press[0];
  assign ev_right = press[1] & ~press[0];
  assign ev_up    = press[2] & ~(|press[1:0]);
  assign ev_down  = press[3] & ~(|press[2:0]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      dvd_load_q <= 1'b0;
      dvs_load_q <= 1'b0;
      trig_q     <= 1'b0;
      rem_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      dvd_ok_q   <= 1'b0;
      dvs_ok_q   <= 1'b0;
      res_ok_q   <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      dvd_load_q <= dvd_load_d;
      dvs_load_q <= dvs_load_d;
      trig_q     <= trig_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      dvd_ok_q   <= dvd_ok_d;
      dvs_ok_q   <= dvs_ok_d;
      res_ok_q   <= res_ok_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dvd_load_d = 1'b0;
    dvs_load_d = 1'b0;
    trig_d     = 1'b0;
    rem_d      = rem_q;
    busy_d     = busy_q;
    err_d      = err_q;
    dvd_ok_d   = dvd_ok_q;
    dvs_ok_d   = dvs_ok_q;
    res_ok_d   = res_ok_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ev_left) begin
          dvd_load_d = 1'b1;
          dvd_ok_d   = 1'b1;
          res_ok_d   = 1'b0;
          rem_d      = 1'b0;
          err_d      = 1'b0;
        end else if (ev_right) begin
          dvs_load_d = 1'b1;
          dvs_ok_d   = 1'b1;
          res_ok_d   = 1'b0;
          rem_d      = 1'b0;
          err_d      = 1'b0;
        end else if (ev_up) begin
          if (dvd_ok_q && dvs_ok_q) begin
            trig_d   = 1'b1;
            busy_d   = 1'b1;
            err_d    = 1'b0;
            to_cnt_d = '0;
            state_d  = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end else if (ev_down && res_ok_q) begin
          rem_d = ~rem_q;
        end
      end
      S_WAIT: begin
        // DIV_DONE is ignored while the trigger pulse itself is still out
        if (!trig_q && DIV_DONE) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          res_ok_d = 1'b1;
          rem_d    = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LAST) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            err_d    = 1'b1;
            res_ok_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dividendLOAD     = dvd_load_q;
  assign divisorLOAD      = dvs_load_q;
  assign trigger          = trig_q;
  assign remainderDISPLAY = rem_q;
  assign busy             = busy_q;
  assign error            = err_q;
  assign state            = state_q;

endmodule

// File: tb/tb_lab3_div_sequencer.sv
// Bench for lab3_div_sequencer: directed scenarios plus randomized buttons, checked each cycle
// against a behavioural model built from button-history windows and a transaction view of the FSM.
module tb_lab3_div_sequencer;

  localparam int DBC = 4;
  localparam int TOC = 16;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       LEFT = 1'b0, RIGHT = 1'b0, UP = 1'b0, DOWN = 1'b0, DIV_DONE = 1'b0;
  logic       dividendLOAD, divisorLOAD, trigger, remainderDISPLAY, busy, error;
  logic [1:0] state;

  lab3_div_sequencer #(
    .DEBOUNCE_CYCLES(DBC),
    .DB_W           (3),
    .TIMEOUT_CYCLES (TOC),
    .TO_W           (5)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .LEFT            (LEFT),
    .RIGHT           (RIGHT),
    .UP              (UP),
    .DOWN            (DOWN),
    .DIV_DONE        (DIV_DONE),
    .dividendLOAD    (dividendLOAD),
    .divisorLOAD     (divisorLOAD),
    .trigger         (trigger),
    .remainderDISPLAY(remainderDISPLAY),
    .busy            (busy),
    .error           (error),
    .state           (state)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fails = 0;
  int cyc = 0;
  int n_dl = 0, n_vl = 0, n_tr = 0, n_busy = 0;
  int last_dl_cyc = 0;

  // Behavioural model state
  logic [15:0] hist [4];
  bit          lvl [4];
  bit          lvl_prev [4];
  bit          m_dl, m_vl, m_tr, m_rem, m_busy, m_err, m_dvd_ok, m_dvs_ok, m_res_ok;
  int          m_wait;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      hist[b]     = '0;
      lvl[b]      = 1'b0;
      lvl_prev[b] = 1'b0;
    end
    m_dl = 0; m_vl = 0; m_tr = 0; m_rem = 0; m_busy = 0; m_err = 0;
    m_dvd_ok = 0; m_dvs_ok = 0; m_res_ok = 0; m_wait = 0;
  endtask

  // One clock edge of the model. A button's accepted level flips once the synchronised
  // level (raw level two edges old) has disagreed with it for DBC consecutive edges.
  task automatic model_edge();
    bit raw [4];
    bit ev [4];
    bit all_diff;
    if (!RST_N) begin
      model_reset();
      return;
    end
    raw[0] = LEFT; raw[1] = RIGHT; raw[2] = UP; raw[3] = DOWN;
    for (int b = 0; b < 4; b++) ev[b] = lvl[b] && !lvl_prev[b];
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= DBC; j++)
        if (hist[b][j] == lvl[b]) all_diff = 1'b0;
      lvl_prev[b] = lvl[b];
      if (all_diff) lvl[b] = !lvl[b];
      hist[b] = {hist[b][14:0], raw[b]};
    end
    m_dl = 0; m_vl = 0; m_tr = 0;
    if (m_busy) begin
      m_wait++;
      if (DIV_DONE && m_wait >= 2) begin
        m_busy = 0; m_res_ok = 1; m_rem = 0;
      end else if (m_wait == TOC) begin
        m_busy = 0; m_err = 1; m_res_ok = 0;
      end
    end else if (ev[0]) begin
      m_dl = 1; m_dvd_ok = 1; m_res_ok = 0; m_rem = 0; m_err = 0;
    end else if (ev[1]) begin
      m_vl = 1; m_dvs_ok = 1; m_res_ok = 0; m_rem = 0; m_err = 0;
    end else if (ev[2]) begin
      if (m_dvd_ok && m_dvs_ok) begin
        m_tr = 1; m_busy = 1; m_err = 0; m_wait = 0;
      end else begin
        m_err = 1;
      end
    end else if (ev[3] && m_res_ok) begin
      m_rem = !m_rem;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle: model follows the rising edge, DUT compared on the falling edge
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    cyc++;
    chk("dividendLOAD", int'(dividendLOAD), int'(m_dl));
    chk("divisorLOAD", int'(divisorLOAD), int'(m_vl));
    chk("trigger", int'(trigger), int'(m_tr));
    chk("remainderDISPLAY", int'(remainderDISPLAY), int'(m_rem));
    chk("busy", int'(busy), int'(m_busy));
    chk("error", int'(error), int'(m_err));
    chk("state", int'(state), m_busy ? 1 : 0);
    if (dividendLOAD) begin n_dl++; last_dl_cyc = cyc; end
    if (divisorLOAD) n_vl++;
    if (trigger) n_tr++;
    if (busy) n_busy++;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: LEFT = v;
      1: RIGHT = v;
      2: UP = v;
      default: DOWN = v;
    endcase
  endtask

  // A clean press: the resulting pulse/level change is visible on the last tick
  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (7) tick();
    set_btn(b, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dl"}, int'(dividendLOAD), 0);
    chk({tag, "_vl"}, int'(divisorLOAD), 0);
    chk({tag, "_tr"}, int'(trigger), 0);
    chk({tag, "_rem"}, int'(remainderDISPLAY), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(error), 0);
    chk({tag, "_state"}, int'(state), 0);
  endtask

  initial begin
    int d0, v0, t0, b0, c0;
    model_reset();
    repeat (3) tick();
    chk_all_zero("reset");
    RST_N = 1'b1;
    repeat (4) tick();

    // Mid-sequence reset, then no spurious pulses after release
    d0 = n_dl;
    press(0);
    chk("t1_left_load", n_dl - d0, 1);
    RIGHT = 1'b1;
    repeat (4) tick();
    RST_N = 1'b0;
    model_reset();
    #1;
    chk_all_zero("midreset");
    RIGHT = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    d0 = n_dl; v0 = n_vl; t0 = n_tr;
    repeat (15) tick();
    chk("t1_no_dl", n_dl - d0, 0);
    chk("t1_no_vl", n_vl - v0, 0);
    chk("t1_no_tr", n_tr - t0, 0);

    // UP with no operands
    t0 = n_tr;
    press(2);
    chk("t3_up_err", int'(error), 1);
    chk("t3_up_no_tr", n_tr - t0, 0);
    repeat (8) tick();

    // Bouncing LEFT gives a single load, seven cycles after it settles
    d0 = n_dl;
    for (int i = 0; i < 6; i++) begin
      LEFT = (i % 2 == 0);
      tick();
    end
    LEFT = 1'b1;
    c0 = cyc;
    repeat (20) tick();
    LEFT = 1'b0;
    chk("t2_one_dl", n_dl - d0, 1);
    chk("t2_dl_latency", last_dl_cyc - c0, 7);
    chk("t2_err_clr", int'(error), 0);
    repeat (8) tick();

    // Load divisor and start
    v0 = n_vl; t0 = n_tr;
    press(1);
    chk("t3_vl", n_vl - v0, 1);
    press(2);
    chk("t3_tr", n_tr - t0, 1);
    chk("t3_busy", int'(busy), 1);
    chk("t3_state", int'(state), 1);
    chk("t3_err", int'(error), 0);

    // Buttons ignored in WAIT; DIV_DONE ten cycles after trigger
    d0 = n_dl;
    LEFT = 1'b1;
    repeat (9) tick();
    chk("t4_busy_before", int'(busy), 1);
    DIV_DONE = 1'b1;
    tick();
    DIV_DONE = 1'b0;
    chk("t4_busy_done", int'(busy), 0);
    chk("t4_state_done", int'(state), 0);
    chk("t4_rem0", int'(remainderDISPLAY), 0);
    chk("t4_no_dl", n_dl - d0, 0);
    LEFT = 1'b0;
    repeat (8) tick();
    press(3);
    chk("t4_rem1", int'(remainderDISPLAY), 1);
    repeat (8) tick();
    press(3);
    chk("t4_rem_back", int'(remainderDISPLAY), 0);
    repeat (8) tick();

    // Timeout after sixteen WAIT cycles
    b0 = n_busy;
    press(2);
    repeat (20) tick();
    chk("t5_busy_len", n_busy - b0, 16);
    chk("t5_err", int'(error), 1);
    chk("t5_busy_off", int'(busy), 0);
    d0 = n_dl; v0 = n_vl;
    LEFT = 1'b1; RIGHT = 1'b1;
    repeat (7) tick();
    LEFT = 1'b0; RIGHT = 1'b0;
    chk("t5_dl_only", n_dl - d0, 1);
    chk("t5_no_vl", n_vl - v0, 0);
    chk("t5_err_clr", int'(error), 0);
    repeat (8) tick();

    // Reset during WAIT clears operand and result flags
    press(2);
    chk("t6_busy", int'(busy), 1);
    repeat (3) tick();
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("t6_busy_rst", int'(busy), 0);
    chk("t6_state_rst", int'(state), 0);
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (8) tick();
    t0 = n_tr;
    press(2);
    chk("t6_up_err", int'(error), 1);
    chk("t6_up_no_tr", n_tr - t0, 0);
    repeat (8) tick();
    press(3);
    chk("t6_down_noeffect", int'(remainderDISPLAY), 0);
    repeat (8) tick();

    // Randomized buttons, divider completion and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) LEFT = ~LEFT;
      if ($urandom_range(0, 7) == 0) RIGHT = ~RIGHT;
      if ($urandom_range(0, 6) == 0) UP = ~UP;
      if ($urandom_range(0, 7) == 0) DOWN = ~DOWN;
      DIV_DONE = ($urandom_range(0, 11) == 0);
      if (!RST_N) begin
        RST_N = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        RST_N = 1'b0;
        model_reset();
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
